// File: rtl/alu_ctrl_pkg.sv
// Shared types for the sequential multiplier: Hack ALU control word and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_ctrl_pkg;

  // Hack ALU control bits in instruction order {zx,nx,zy,ny,f,no}.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD    = 6'b000010; // x + y
  localparam alu_ctrl_t ALU_PASS_X = 6'b001010; // x & 0xFFFF
  localparam alu_ctrl_t ALU_ZERO   = 6'b101010; // constant 0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/response bundle of the multiplier: operand pair in, product and flags out.
// Latency: n/a (wires only).
// Backpressure: req_ready gates requests, rsp_ready holds the product until taken.
interface alu_mul_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] product;
  logic        zr;
  logic        ng;

  // Requester side.
  modport master (
    output req_valid, a, b, rsp_ready,
    input  req_ready, rsp_valid, product, zr, ng
  );

  // Multiplier side.
  modport slave (
    input  req_valid, a, b, rsp_ready,
    output req_ready, rsp_valid, product, zr, ng
  );
endinterface

// File: rtl/alu.sv
// Hack ALU: combinational 16-bit x/y function selected by zx/nx/zy/ny/f/no.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y operands; six control bits; out result, zr (out==0), ng (out[15]).
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] x_z, x_n, y_z, y_n, f_out;

  assign x_z   = zx ? 16'h0000 : x;
  assign x_n   = nx ? ~x_z : x_z;
  assign y_z   = zy ? 16'h0000 : y;
  assign y_n   = ny ? ~y_z : y_z;
  assign f_out = f ? (x_n + y_n) : (x_n & y_n);
  assign out   = no ? ~f_out : f_out;
  assign zr    = (out == 16'h0000);
  assign ng    = out[15];
endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 multiplier (low 16 bits) built around one shared Hack ALU.
// Latency: 32 cycles accept-to-rsp_valid; with EARLY_EXIT, 2*k (k = top set bit of b + 1, min 1).
// Backpressure: one operation in flight; req_ready=0 until the response is taken with rsp_ready.
// Ports: clk, rst_n (sync, active-low); bus = request (a, b) / response (product, zr, ng).
module alu_mul_seq
  import alu_ctrl_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mul_seq_if.slave bus
);
  mul_state_t  state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] mplier_shr;

  alu_ctrl_t   alu_ctrl;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zr, alu_ng;

  assign mplier_shr = {1'b0, mplier_q[15:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    alu_ctrl = ALU_ZERO;
    alu_x    = '0;
    alu_y    = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          acc_d    = '0;
          mcand_d  = bus.a;
          mplier_d = bus.b;
          cnt_d    = '0;
          state_d  = ADD;
        end
      end
      ADD: begin
        alu_ctrl = ALU_ADD;
        alu_x    = acc_q;
        alu_y    = mcand_q;
        if (mplier_q[0]) acc_d = alu_out;
        state_d = DBL;
      end
      DBL: begin
        // Doubling the multiplicand through the ALU keeps all arithmetic in one adder.
        alu_ctrl = ALU_ADD;
        alu_x    = mcand_q;
        alu_y    = mcand_q;
        mcand_d  = alu_out;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + 5'd1;
        if ((cnt_q == 5'd15) || (EARLY_EXIT && (mplier_shr == 16'h0000)))
          state_d = DONE;
        else
          state_d = ADD;
      end
      DONE: begin
        // Flags come from the ALU passing acc through, so they match Hack semantics.
        alu_ctrl = ALU_PASS_X;
        alu_x    = acc_q;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  alu u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .zx  (alu_ctrl.zx),
    .nx  (alu_ctrl.nx),
    .zy  (alu_ctrl.zy),
    .ny  (alu_ctrl.ny),
    .f   (alu_ctrl.f),
    .no  (alu_ctrl.no),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.product   = (state_q == DONE) ? acc_q : 16'h0000;
  assign bus.zr        = (state_q == DONE) ? alu_zr : 1'b0;
  assign bus.ng        = (state_q == DONE) ? alu_ng : 1'b0;
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 16-bit multiplier that reuses one instance of the existing Hack `alu`. It accepts an operand pair over a valid/ready request channel. It sequences the ALU control bits (zx/nx/zy/ny/f/no) through shift-and-add iterations and returns the low 16 bits of the product with ALU-style zr/ng flags. It sits beside the CPU datapath as the multiply unit the Hack ISA lacks natively, and gives the emulator a hardware reference for its software multiply routine.

## Interface
- `EARLY_EXIT`, default 0: when 1, stop iterating once the remaining multiplier bits are all zero.
- `clk  in  1  single clock, all state updates on rising edge`
- `rst_n  in  1  reset, synchronous, active-low`
- `req_valid  in  1  operand pair valid`
- `req_ready  out  1  block idle and able to accept`
- `a  in  16  multiplicand, two's complement`
- `b  in  16  multiplier, two's complement`
- `rsp_valid  out  1  product valid`
- `rsp_ready  in  1  consumer takes product`
- `product  out  16  (a*b) mod 2^16`
- `zr  out  1  product == 0`
- `ng  out  1  product[15]`

## Operation
- States: IDLE, ADD, DBL, DONE.
- Registers: acc[15:0], mcand[15:0], mplier[15:0], cnt[4:0].
- IDLE:
  - req_ready=1; ALU driven with ALU_ZERO.
  - On req_valid: acc<=0, mcand<=a, mplier<=b, cnt<=0, go to ADD.
- ADD:
  - ALU x=acc, y=mcand, ctrl=ALU_ADD.
  - If mplier[0]: acc<=alu.out; else acc is held.
  - Go to DBL.
- DBL:
  - ALU x=mcand, y=mcand, ctrl=ALU_ADD.
  - mcand<=alu.out, mplier<=mplier>>1 (logical), cnt<=cnt+1.
  - Go to DONE if cnt==15, or if EARLY_EXIT and (mplier>>1)==0; else go to ADD.
- DONE:
  - ALU x=acc, ctrl=ALU_PASS_X.
  - product=acc; zr and ng are taken from the ALU outputs; rsp_valid=1.
  - On rsp_ready, go to IDLE.
- Arithmetic:
  - All sums wrap mod 2^16 inside the ALU; no overflow flag.
  - The low 16 bits are correct for both signed and unsigned interpretations.
- Outputs stay stable in DONE until the handshake completes, even if a, b or req_valid change.
- req_valid outside IDLE is ignored (req_ready=0).

## Timing
- Acceptance edge E0 (IDLE, req_valid=1). ADD/DBL pairs occupy cycles E0+1 … E0+32.
- With EARLY_EXIT=0, rsp_valid rises after edge E0+32, i.e. a fixed latency of 32 cycles.
- With EARLY_EXIT=1, latency is 2·k, where k = max(1, index of highest set bit of b + 1); for b=0, k=1.
- Response edge R (DONE, rsp_ready=1) returns the block to IDLE. req_ready=1 from R+1.
- There is no same-edge re-accept. Minimum request spacing is 34 cycles with EARLY_EXIT=0.
- rsp_ready held high before DONE completes the handshake on the first DONE cycle.
- Reset, i.e. rst_n=0 sampled at an edge, in any state including mid-iteration:
  - State goes to IDLE; acc, mcand, mplier and cnt go to 0.
  - Any in-flight result is discarded with no response.
- Output values after reset: req_ready=1, rsp_valid=0, product=0, zr=0, ng=0. Outside DONE, product/zr/ng are forced to 0.

## Structure
- Package `alu_ctrl_pkg` holds:
  - `alu_ctrl_t`: packed struct {zx,nx,zy,ny,f,no}.
  - Constants ALU_ADD=000010, ALU_PASS_X=001010, ALU_ZERO=101010.
  - `mul_state_t` enum.
- One sub-module: the existing `alu`, instantiated once. Its x/y inputs are muxed by state.
- No other arithmetic: only the shift and the counter increment are local.

## Test plan
- a=3, b=5, EARLY_EXIT=0; rsp_ready=1 -> rsp_valid exactly 32 cycles after accept; product=15, zr=0, ng=0; req_ready back at R+1.
- a=-3, b=5 -> product=0xFFF1 (-15), ng=1, zr=0.
- a=200, b=200 -> product=0x9C40 (wraps to -25536), ng=1; and a=300, b=300 -> 0x5F90 (24464), ng=0.
- a=1234, b=0 -> product=0, zr=1, ng=0. With EARLY_EXIT=1, the same request returns after 2 cycles, and b=5 returns after 6 cycles.
- Back-pressure: hold rsp_ready=0 for 10 cycles in DONE while toggling a/b/req_valid -> product/flags stable, req_ready=0 throughout, no second accept.
- Reset mid-op: rst_n=0 for one edge during iteration 7 -> next cycle IDLE, req_ready=1, rsp_valid=0. A fresh request a=7, b=6 then returns 42 after 32 cycles.
